// File: rtl/id_ex_alu_stage.sv
// -----------------------------------------------------------------------------
// id_ex_alu_stage
//
// ID/EX pipeline register for the RV32I core. One decoded instruction is
// captured per cycle. The stage selects the ALU operands, generates the 4-bit
// ALU operation code, and registers the memory, write-back and branch control
// for the execute stage. The hazard unit can hold the stage (stall) or load a
// bubble into it (flush).
//
// Ports
//   clk, reset        core clock (rising edge), async active-high reset
//   valid_in          decode stage presents an instruction this cycle
//   stall / flush     hold all outputs / load a bubble (flush wins)
//   opcode, funct3,   instruction fields [6:0], [14:12], bit 30
//   funct7b5
//   pc_in, rs1_data,  instruction address, register operands,
//   rs2_data, imm     sign-extended immediate
//   rd_in             destination register
//   alu_a, alu_b      registered ALU operands
//   operation         registered ALU operation code
//   store_data        registered rs2_data
//   pc_out, imm_out   registered pc / immediate for the branch-target adder
//   rd_out            registered destination register
//   valid_out, reg_write, mem_read, mem_write, mem_to_reg, branch, illegal
//                     registered control bits
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module id_ex_alu_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic              funct7b5,
   input  logic [XLEN-1:0]   pc_in,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic [XLEN-1:0]   imm,
   input  logic [REG_AW-1:0] rd_in,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [3:0]        operation,
   output logic [XLEN-1:0]   store_data,
   output logic [XLEN-1:0]   pc_out,
   output logic [XLEN-1:0]   imm_out,
   output logic [REG_AW-1:0] rd_out,
   output logic              valid_out,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_to_reg,
   output logic              branch,
   output logic              illegal
);

   // opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALU operation codes as consumed by the execute-stage ALU
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;  // unsigned compare in the ALU
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;
   localparam logic [3:0] ALU_BEQ = 4'b1000;
   localparam logic [3:0] ALU_BNE = 4'b1001;
   localparam logic [3:0] ALU_BLT = 4'b1010;
   localparam logic [3:0] ALU_BGE = 4'b1011;

   // Whole ID/EX entry. An all-zero entry is a bubble.
   typedef struct packed {
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [3:0]        op;
      logic [XLEN-1:0]   sd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rd;
      logic              valid;
      logic              rw;
      logic              mr;
      logic              mw;
      logic              m2r;
      logic              br;
      logic              ill;
   } ex_t;

   ex_t dec;
   ex_t ex_q;

   // ---------------------------------------------------------------------------
   // Decode of the instruction currently on the inputs
   // ---------------------------------------------------------------------------
   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.a     = rs1_data;
      dec.b     = rs2_data;
      dec.op    = ALU_ADD;
      dec.sd    = rs2_data;
      dec.pc    = pc_in;
      dec.imm   = imm;
      dec.rd    = rd_in;

      case (opcode)
         OP_R, OP_I: begin
            dec.rw = 1'b1;
            if (opcode == OP_I)
               dec.b = imm;
            case (funct3)
               // funct7b5 selects SUB only for register-register; in ADDI
               // bit 30 is part of the immediate.
               3'b000:  dec.op = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  dec.op = ALU_SLL;
               3'b010:  dec.op = ALU_SLT;
               3'b011:  dec.op = ALU_SLT;
               3'b100:  dec.op = ALU_XOR;
               // The ALU has no arithmetic shift, so SRA/SRAI are rejected.
               3'b101:  begin
                  if (funct7b5)
                     dec.ill = 1'b1;
                  else
                     dec.op = ALU_SRL;
               end
               3'b110:  dec.op = ALU_OR;
               default: dec.op = ALU_AND;
            endcase
         end
         OP_LOAD: begin
            dec.b   = imm;
            dec.mr  = 1'b1;
            dec.m2r = 1'b1;
            dec.rw  = 1'b1;
         end
         OP_STORE: begin
            dec.b  = imm;
            dec.mw = 1'b1;
         end
         OP_BRANCH: begin
            dec.br = 1'b1;
            case (funct3)
               3'b000:  dec.op = ALU_BEQ;
               3'b001:  dec.op = ALU_BNE;
               3'b100:  dec.op = ALU_BLT;
               3'b101:  dec.op = ALU_BGE;
               default: dec.ill = 1'b1;
            endcase
         end
         OP_LUI: begin
            dec.a  = '0;
            dec.b  = imm;
            dec.rw = 1'b1;
         end
         OP_AUIPC: begin
            dec.a  = pc_in;
            dec.b  = imm;
            dec.rw = 1'b1;
         end
         default: dec.ill = 1'b1;
      endcase

      // An illegal entry travels down the pipe as a valid, side-effect-free
      // slot so the trap logic can see it; its data fields are kept.
      if (dec.ill) begin
         dec.op  = ALU_ADD;
         dec.rw  = 1'b0;
         dec.mr  = 1'b0;
         dec.mw  = 1'b0;
         dec.m2r = 1'b0;
         dec.br  = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Pipeline register: reset > flush > stall > capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ex_q <= '0;
      else if (flush)
         ex_q <= '0;
      else if (!stall)
         ex_q <= valid_in ? dec : '0;
   end

   assign alu_a      = ex_q.a;
   assign alu_b      = ex_q.b;
   assign operation  = ex_q.op;
   assign store_data = ex_q.sd;
   assign pc_out     = ex_q.pc;
   assign imm_out    = ex_q.imm;
   assign rd_out     = ex_q.rd;
   assign valid_out  = ex_q.valid;
   assign reg_write  = ex_q.rw;
   assign mem_read   = ex_q.mr;
   assign mem_write  = ex_q.mw;
   assign mem_to_reg = ex_q.m2r;
   assign branch     = ex_q.br;
   assign illegal    = ex_q.ill;

endmodule
